// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and sizes for the 8-input round-robin mux scheduler.
package mux8_sched_pkg;

  localparam int N_IN   = 8;
  localparam int SEL_W  = 3;
  localparam int BEAT_W = 4;
  localparam int GAP_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  function automatic logic [N_IN-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// Request/data/grant bundle between the requesters and the scheduler.
interface mux8_rr_scheduler_if;
  import mux8_sched_pkg::*;

  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  I;
  logic [SEL_W-1:0] S;
  logic [N_IN-1:0]  gnt;
  logic             O;
  logic             O_vld;
  logic             busy;

  modport master (
    output req, I,
    input  S, gnt, O, O_vld, busy
  );

  modport slave (
    input  req, I,
    output S, gnt, O, O_vld, busy
  );

endinterface

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// Circular first-set search over 8 requests, starting at ptr and wrapping 7->0.
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_IN-1:0]  rot;
  logic [SEL_W-1:0] off;

  // Rotate so ptr lands at bit 0, then take the lowest set bit as the offset.
  always_comb begin
    rot   = N_IN'({req, req} >> ptr);
    found = |req;
    off   = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 bit mux; bursts of up to BURST_MAX beats.
// Define MUX8_SCHED_OUT_REG_EN to register O/O_vld (one clk later than the beat).
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int BURST_MAX  = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  mux8_rr_scheduler_if.slave bus
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [N_IN-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             o_c;
  logic             o_vld_c;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // gnt is zero outside BUSY, so the beat qualifier needs no state decode.
  always_comb begin
    o_vld_c = gnt_q[s_q] & bus.req[s_q];
    o_c     = o_vld_c & bus.I[s_q];
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          s_d     = pick_idx;
          gnt_d   = onehot(pick_idx);
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (o_vld_c) beat_d = beat_q + BEAT_W'(1);
        if (!bus.req[s_q] || (o_vld_c && beat_q == BEAT_LAST)) begin
          gnt_d   = '0;
          ptr_d   = s_q + SEL_W'(1);
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

`ifdef MUX8_SCHED_OUT_REG_EN
  logic o_q;
  logic o_vld_q;

  // Output stage keeps a fixed one-clock shift, independent of S changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q     <= 1'b0;
      o_vld_q <= 1'b0;
    end else begin
      o_q     <= o_c;
      o_vld_q <= o_vld_c;
    end
  end

  assign bus.O     = o_q;
  assign bus.O_vld = o_vld_q;
`else
  assign bus.O     = o_c;
  assign bus.O_vld = o_vld_c;
`endif

  assign bus.S    = s_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed-vector bench for mux8_rr_scheduler (BURST_MAX=4, GAP_CYCLES=1).
module tb_mux8_rr_scheduler;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       o;
    logic       o_vld;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic prev_o;
  logic prev_vld;
  vec_t vecs[$];

  mux8_rr_scheduler_if bus ();

  mux8_rr_scheduler #(
    .BURST_MAX  (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic [7:0] rq, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] g, input logic o,
                        input logic v, input logic b);
    vec_t t;
    t.rst = r; t.req = rq; t.din = d; t.s = s; t.gnt = g;
    t.o = o; t.o_vld = v; t.busy = b;
    vecs.push_back(t);
  endtask

  // Inputs change just after an edge; outputs are sampled mid-cycle.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst     = v.rst;
    bus.req = v.req;
    bus.I   = v.din;
    #1;
  endtask

  task automatic checkField(input int row, input string name,
                            input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL row%0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  // With the output register the O/O_vld seen now belong to the previous row.
  task automatic checkOutput(input int row, input vec_t v);
    logic exp_o;
    logic exp_vld;
`ifdef MUX8_SCHED_OUT_REG_EN
    exp_o    = v.rst ? 1'b0 : prev_o;
    exp_vld  = v.rst ? 1'b0 : prev_vld;
    prev_o   = v.o;
    prev_vld = v.o_vld;
`else
    exp_o    = v.o;
    exp_vld  = v.o_vld;
`endif
    checkField(row, "S",     8'(bus.S),     8'(v.s));
    checkField(row, "gnt",   bus.gnt,       v.gnt);
    checkField(row, "O",     8'(bus.O),     8'(exp_o));
    checkField(row, "O_vld", 8'(bus.O_vld), 8'(exp_vld));
    checkField(row, "busy",  8'(bus.busy),  8'(v.busy));
  endtask

  initial begin
    logic       exp_bits [8];
    logic [7:0] di;
    int         k8;
    checks   = 0;
    errors   = 0;
    prev_o   = 1'b0;
    prev_vld = 1'b0;
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.I    = 8'hE5;
    di       = 8'hE5;
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Single requester 2: burst, gap, re-grant, then drop mid-burst.
    //     rst   req    din    S     gnt    O  vld busy
    addVec(1, 8'h00, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h04, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h04, di,    3'd2, 8'h04, 1, 1, 1);
    addVec(0, 8'h04, di,    3'd2, 8'h04, 1, 1, 1);
    addVec(0, 8'h04, 8'hE1, 3'd2, 8'h04, 0, 1, 1);
    addVec(0, 8'h04, di,    3'd2, 8'h04, 1, 1, 1);
    addVec(0, 8'h04, di,    3'd2, 8'h00, 0, 0, 1);
    addVec(0, 8'h04, di,    3'd2, 8'h00, 0, 0, 0);
    addVec(0, 8'h04, di,    3'd2, 8'h04, 1, 1, 1);
    addVec(0, 8'h00, di,    3'd2, 8'h04, 0, 0, 1);
    addVec(0, 8'h00, di,    3'd2, 8'h00, 0, 0, 1);
    addVec(0, 8'h00, di,    3'd2, 8'h00, 0, 0, 0);
    // Early drop: 2 beats from 0, gap, 4 beats from 3, then ptr=4 picks 0.
    addVec(1, 8'h00, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h09, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h09, di,    3'd0, 8'h01, 1, 1, 1);
    addVec(0, 8'h09, di,    3'd0, 8'h01, 1, 1, 1);
    addVec(0, 8'h08, di,    3'd0, 8'h01, 0, 0, 1);
    addVec(0, 8'h08, di,    3'd0, 8'h00, 0, 0, 1);
    addVec(0, 8'h08, di,    3'd0, 8'h00, 0, 0, 0);
    for (int b = 0; b < 4; b++) addVec(0, 8'h08, di, 3'd3, 8'h08, 0, 1, 1);
    addVec(0, 8'h08, di,    3'd3, 8'h00, 0, 0, 1);
    addVec(0, 8'h09, di,    3'd3, 8'h00, 0, 0, 0);
    addVec(0, 8'h09, di,    3'd0, 8'h01, 1, 1, 1);
    // Async reset in the middle of a burst to 5, then restart from 0.
    addVec(1, 8'h00, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h20, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h20, di,    3'd5, 8'h20, 1, 1, 1);
    addVec(1, 8'h20, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h21, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h21, di,    3'd0, 8'h01, 1, 1, 1);
    // Wrap: drop 6 immediately to set ptr=7, then 7 before 0; others toggle.
    addVec(1, 8'h00, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h40, di,    3'd0, 8'h00, 0, 0, 0);
    addVec(0, 8'h00, di,    3'd6, 8'h40, 0, 0, 1);
    addVec(0, 8'h81, di,    3'd6, 8'h00, 0, 0, 1);
    addVec(0, 8'h81, di,    3'd6, 8'h00, 0, 0, 0);
    addVec(0, 8'h81, di,    3'd7, 8'h80, 1, 1, 1);
    addVec(0, 8'h80, di,    3'd7, 8'h80, 1, 1, 1);
    addVec(0, 8'hFF, di,    3'd7, 8'h80, 1, 1, 1);
    addVec(0, 8'h81, di,    3'd7, 8'h80, 1, 1, 1);
    addVec(0, 8'h81, di,    3'd7, 8'h00, 0, 0, 1);
    addVec(0, 8'h81, di,    3'd7, 8'h00, 0, 0, 0);
    addVec(0, 8'h81, di,    3'd0, 8'h01, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // All requesters: grants 0..7,0 with four beats each and one gap cycle.
    begin
      vec_t t;
      int   row;
      row = 1000;
      t.rst = 1; t.req = 8'h00; t.din = di; t.s = 3'd0; t.gnt = 8'h00;
      t.o = 0; t.o_vld = 0; t.busy = 0;
      applyStimulus(t);
      checkOutput(row++, t);
      t.rst = 0;
      t.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
        k8 = k % 8;
        t.s = (k == 0) ? 3'd0 : 3'((k - 1) % 8);
        t.gnt = 8'h00; t.o = 0; t.o_vld = 0; t.busy = 0;
        applyStimulus(t);
        checkOutput(row++, t);
        t.s = 3'(k8);
        t.gnt = 8'h01 << k8;
        t.o = exp_bits[k8]; t.o_vld = 1; t.busy = 1;
        for (int b = 0; b < 4; b++) begin
          applyStimulus(t);
          checkOutput(row++, t);
        end
        t.gnt = 8'h00; t.o = 0; t.o_vld = 0; t.busy = 1;
        applyStimulus(t);
        checkOutput(row++, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
